// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC generator and its decode-side consumer.
package fetch_pkg;

  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } fetch_slot_t;

  // Instruction addresses are word aligned; the low two bits are never fetched.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stat_ctr.sv
// Saturating event counter with synchronous active-low reset.
module fetch_stat_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator feeding the BTB lookup and the IF/ID handshake.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STAT_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_valid,
  output logic [31:0] pc_in,
  input  logic        pred_valid,
  input  logic [31:0] pred_target,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_fetch_cnt,
  output logic [STAT_W-1:0] stat_taken_cnt,
  output logic [STAT_W-1:0] stat_redirect_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  fetch_slot_t     slot_q, slot_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot_d  = slot_q;
    unique case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        if (if_ready) begin
          slot_d.valid       = 1'b1;
          slot_d.pc          = pc_q;
          slot_d.pred_taken  = pred_valid;
          slot_d.pred_target = pred_valid ? pred_target : '0;
          pc_d               = pred_valid ? align_pc(pred_target)
                                          : pc_q + PC_W'(INSTR_BYTES);
        end
      end
      FLUSH: begin
        // Bubble lets the resolving branch's BTB write land before re-lookup.
        slot_d.valid = 1'b0;
        state_d      = RUN;
      end
      default: state_d = BOOT;
    endcase
    // A redirect beats any accept or prediction in the same cycle.
    if (redirect_valid) begin
      pc_d         = align_pc(redirect_pc);
      slot_d.valid = 1'b0;
      state_d      = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
    end
  end

  assign fetch_valid    = (state_q == RUN);
  assign pc_in          = pc_q;
  assign if_valid       = slot_q.valid;
  assign if_pc          = slot_q.pc;
  assign if_pred_taken  = slot_q.pred_taken;
  assign if_pred_target = slot_q.pred_target;

`ifdef FETCH_STATS_EN
  logic accept;
  assign accept = (state_q == RUN) && if_ready && !redirect_valid;

  fetch_stat_ctr #(.W(STAT_W)) u_fetch_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .cnt   (stat_fetch_cnt)
  );

  fetch_stat_ctr #(.W(STAT_W)) u_taken_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && pred_valid),
    .cnt   (stat_taken_cnt)
  );

  fetch_stat_ctr #(.W(STAT_W)) u_redirect_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_valid),
    .cnt   (stat_redirect_cnt)
  );
`endif

endmodule
